// File: rtl/rename_unit.sv
// Register-rename stage: speculative and retirement RATs, bit-vector free list,
// intra-group bypass, and one-cycle flush recovery from the retirement RAT.
module rename_unit #(
  parameter int WIDTH     = 2,
  parameter int CWIDTH    = 2,
  parameter int ARCH_REGS = 32,
  parameter int PHYS_REGS = 64,
  localparam int AW = $clog2(ARCH_REGS),
  localparam int PW = $clog2(PHYS_REGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_slot_v,
  input  logic [WIDTH*AW-1:0]  in_rs1,
  input  logic [WIDTH*AW-1:0]  in_rs2,
  input  logic [WIDTH*AW-1:0]  in_rd,
  input  logic [WIDTH-1:0]     in_we,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_slot_v,
  output logic [WIDTH*PW-1:0]  out_ps1,
  output logic [WIDTH*PW-1:0]  out_ps2,
  output logic [WIDTH*PW-1:0]  out_pd,
  output logic [WIDTH*PW-1:0]  out_old_pd,
  input  logic [CWIDTH-1:0]    commit_v,
  input  logic [CWIDTH*AW-1:0] commit_rd,
  input  logic [CWIDTH*PW-1:0] commit_pd,
  input  logic [CWIDTH*PW-1:0] commit_old_pd,
  input  logic                 flush,
  output logic [PW:0]          free_count
);

  logic [PW-1:0]        spec_rat_reg  [ARCH_REGS];
  logic [PW-1:0]        spec_rat_next [ARCH_REGS];
  logic [PW-1:0]        ret_rat_reg   [ARCH_REGS];
  logic [PW-1:0]        ret_rat_next  [ARCH_REGS];
  logic [PHYS_REGS-1:0] free_vec_reg, free_vec_next, freed, alloc_mask, mapped;
  logic [PW:0]          free_count_reg, free_count_next;

  logic                 out_valid_reg;
  logic [WIDTH-1:0]     out_slot_v_reg;
  logic [WIDTH*PW-1:0]  out_ps1_reg, out_ps2_reg, out_pd_reg, out_old_pd_reg;

  logic [AW-1:0]        rs1_a [WIDTH];
  logic [AW-1:0]        rs2_a [WIDTH];
  logic [AW-1:0]        rd_a  [WIDTH];
  logic [AW-1:0]        crd_a  [CWIDTH];
  logic [PW-1:0]        cpd_a  [CWIDTH];
  logic [PW-1:0]        cold_a [CWIDTH];
  logic [WIDTH-1:0]     need;
  logic [PW-1:0]        ps1_c [WIDTH];
  logic [PW-1:0]        ps2_c [WIDTH];
  logic [PW-1:0]        pd_c  [WIDTH];
  logic [PW-1:0]        old_c [WIDTH];
  logic [WIDTH*PW-1:0]  ps1_pack, ps2_pack, pd_pack, old_pack;
  logic                 accept;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_slot
      assign rs1_a[gi] = in_rs1[gi*AW +: AW];
      assign rs2_a[gi] = in_rs2[gi*AW +: AW];
      assign rd_a[gi]  = in_rd[gi*AW +: AW];
      assign need[gi]  = in_slot_v[gi] && in_we[gi] && (rd_a[gi] != '0);
      assign ps1_pack[gi*PW +: PW] = ps1_c[gi];
      assign ps2_pack[gi*PW +: PW] = ps2_c[gi];
      assign pd_pack[gi*PW +: PW]  = pd_c[gi];
      assign old_pack[gi*PW +: PW] = old_c[gi];
    end
    for (genvar gi = 0; gi < CWIDTH; gi++) begin : g_commit
      assign crd_a[gi]  = commit_rd[gi*AW +: AW];
      assign cpd_a[gi]  = commit_pd[gi*PW +: PW];
      assign cold_a[gi] = commit_old_pd[gi*PW +: PW];
    end
  endgenerate

  assign in_ready = !rst && !flush && (free_count_reg >= (PW+1)'(WIDTH)) &&
                    (!out_valid_reg || out_ready);
  assign accept   = in_valid && in_ready;

  // Needing slots take free registers lowest-first, in slot order.
  always_comb begin
    logic [PHYS_REGS-1:0] avail;
    logic [PW-1:0]        pick;
    logic                 found;
    avail = free_vec_reg;
    for (int i = 0; i < WIDTH; i++) begin
      pick  = '0;
      found = 1'b0;
      for (int p = 0; p < PHYS_REGS; p++) begin
        if (!found && avail[p]) begin
          pick  = PW'(p);
          found = 1'b1;
        end
      end
      pd_c[i] = need[i] ? pick : '0;
      if (need[i]) avail[pick] = 1'b0;
    end
    alloc_mask = free_vec_reg & ~avail;
  end

  // Later slots see earlier slots' new mappings; the highest earlier writer wins.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      ps1_c[i] = (rs1_a[i] == '0) ? '0 : spec_rat_reg[rs1_a[i]];
      ps2_c[i] = (rs2_a[i] == '0) ? '0 : spec_rat_reg[rs2_a[i]];
      old_c[i] = spec_rat_reg[rd_a[i]];
      for (int j = 0; j < WIDTH; j++) begin
        if (j < i && need[j]) begin
          if (rd_a[j] == rs1_a[i]) ps1_c[i] = pd_c[j];
          if (rd_a[j] == rs2_a[i]) ps2_c[i] = pd_c[j];
          if (rd_a[j] == rd_a[i])  old_c[i] = pd_c[j];
        end
      end
      if (!in_slot_v[i]) begin
        ps1_c[i] = '0;
        ps2_c[i] = '0;
      end
      if (!need[i]) old_c[i] = '0;
    end
  end

  always_comb begin
    ret_rat_next = ret_rat_reg;
    freed        = '0;
    for (int k = 0; k < CWIDTH; k++) begin
      if (commit_v[k] && crd_a[k] != '0) begin
        ret_rat_next[crd_a[k]] = cpd_a[k];
        freed[cold_a[k]]       = 1'b1;
      end
    end
    mapped = '0;
    for (int a = 0; a < ARCH_REGS; a++) mapped[ret_rat_next[a]] = 1'b1;

    spec_rat_next = spec_rat_reg;
    if (flush) begin
      spec_rat_next = ret_rat_next;
      free_vec_next = ~mapped;
    end else begin
      if (accept) begin
        for (int i = 0; i < WIDTH; i++)
          if (need[i]) spec_rat_next[rd_a[i]] = pd_c[i];
      end
      free_vec_next = (free_vec_reg & ~(accept ? alloc_mask : '0)) | freed;
    end

    free_count_next = '0;
    for (int p = 0; p < PHYS_REGS; p++)
      free_count_next = free_count_next + (PW+1)'(free_vec_next[p]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int a = 0; a < ARCH_REGS; a++) begin
        spec_rat_reg[a] <= PW'(a);
        ret_rat_reg[a]  <= PW'(a);
      end
      for (int p = 0; p < PHYS_REGS; p++) free_vec_reg[p] <= (p >= ARCH_REGS);
      free_count_reg <= (PW+1)'(PHYS_REGS - ARCH_REGS);
      out_valid_reg  <= 1'b0;
      out_slot_v_reg <= '0;
      out_ps1_reg    <= '0;
      out_ps2_reg    <= '0;
      out_pd_reg     <= '0;
      out_old_pd_reg <= '0;
    end else begin
      spec_rat_reg   <= spec_rat_next;
      ret_rat_reg    <= ret_rat_next;
      free_vec_reg   <= free_vec_next;
      free_count_reg <= free_count_next;
      if (flush) begin
        out_valid_reg <= 1'b0;
      end else if (accept) begin
        out_valid_reg  <= 1'b1;
        out_slot_v_reg <= in_slot_v;
        out_ps1_reg    <= ps1_pack;
        out_ps2_reg    <= ps2_pack;
        out_pd_reg     <= pd_pack;
        out_old_pd_reg <= old_pack;
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid  = out_valid_reg;
  assign out_slot_v = out_slot_v_reg;
  assign out_ps1    = out_ps1_reg;
  assign out_ps2    = out_ps2_reg;
  assign out_pd     = out_pd_reg;
  assign out_old_pd = out_old_pd_reg;
  assign free_count = free_count_reg;

endmodule
